// File: rtl/hs_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing handshake.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        ERROR   = 2'd3
    } hs_state_e;

    localparam logic MODE_4PH = 1'b0;
    localparam logic MODE_2PH = 1'b1;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer; output is the input after STAGES clocks.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a req/ack CDC handshake: holds a word on data_out while req is pending,
// supports 4-phase and 2-phase signalling, with per-wait timeout and a transfer counter.
module cdc_handshake_tx
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              mode,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  xfer_cnt
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    hs_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mode_q, mode_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  xfer_q, xfer_d;
    logic              terr_q, terr_d;
    logic              abort_q, abort_d;
    logic              ack_s;
    logic              tmo_hit;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ack_in),
        .q_o   (ack_s)
    );

    assign src_ready   = rst_n && ena && (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign req_out     = req_q;
    assign data_out    = data_q;
    assign timeout_err = terr_q;
    assign xfer_cnt    = xfer_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        mode_d  = mode_q;
        tmo_d   = tmo_q;
        xfer_d  = xfer_q;
        terr_d  = terr_q;
        abort_d = abort_q;
        tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

        unique case (state_q)
            IDLE: begin
                if (src_valid && src_ready) begin
                    data_d  = src_data;
                    mode_d  = mode;
                    req_d   = (mode == MODE_2PH) ? ~req_q : 1'b1;
                    abort_d = 1'b0;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if ((mode_q == MODE_2PH) ? (ack_s == req_q) : ack_s) begin
                    if (mode_q == MODE_2PH) begin
                        xfer_d  = xfer_q + CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        req_d   = 1'b0;
                        state_d = RELEASE;
                    end
                end else if (tmo_hit) begin
                    terr_d  = 1'b1;
                    state_d = ERROR;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    // A release entered from error recovery closes an aborted transfer.
                    if (!abort_q) begin
                        xfer_d = xfer_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    terr_d  = 1'b1;
                    state_d = ERROR;
                end
            end
            ERROR: begin
                if (err_clr) begin
                    terr_d = 1'b0;
                    if (mode_q == MODE_2PH) begin
                        req_d   = ack_s;
                        state_d = IDLE;
                    end else begin
                        req_d   = 1'b0;
                        abort_d = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q == ASSERT || state_q == RELEASE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            mode_q  <= MODE_4PH;
            tmo_q   <= '0;
            xfer_q  <= '0;
            terr_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            tmo_q   <= tmo_d;
            xfer_q  <= xfer_d;
            terr_q  <= terr_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed corner cases plus randomized traffic
// against a transaction-level model with a destination that echoes req after a fixed delay.
module tb_cdc_handshake_tx;

    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int TMO  = 16;
    localparam int CW   = 2;
    localparam int ECHO = 3;
    // Cycles from a req edge until the block observes the matching ack edge.
    localparam int HALF = ECHO + SS + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          mode = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          err_clr = 1'b0;
    logic          tie0 = 1'b0;
    logic          src_ready, req_out, ack_in, busy, timeout_err;
    logic [DW-1:0] data_out;
    logic [CW-1:0] xfer_cnt;
    logic [ECHO-1:0] req_dly;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state.
    int          m_age = -1;
    int          m_h1 = HALF;
    int          m_cnt = 0;
    logic        m_req = 1'b0;
    logic        m_mode = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic        prev_req = 1'b0;
    int          n_rise = 0;
    int          n_tog = 0;

    typedef struct {
        logic ena;
        logic valid;
        logic exp_ready;
    } vec_t;
    vec_t tbl[4];
    int   exp_wrap[5];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_dly <= '0;
        else        req_dly <= {req_dly[ECHO-2:0], req_out};
    end
    assign ack_in = tie0 ? 1'b0 : req_dly[ECHO-1];

    cdc_handshake_tx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .mode        (mode),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .xfer_cnt    (xfer_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic guard_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic model_check();
        logic b;
        b = (m_age >= 0);
        chk("busy", busy, b);
        chk("src_ready", src_ready, !b && ena);
        chk("req_out", req_out, m_req);
        chk("data_out", data_out, m_data);
        chk("xfer_cnt", xfer_cnt, m_cnt % (1 << CW));
        chk("timeout_err", timeout_err, 0);
        if (req_out && !prev_req) n_rise++;
        if (req_out !== prev_req) n_tog++;
        prev_req = req_out;
    endtask

    // Check the state left by the previous edge, then drive and advance the model one edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic e, input logic md);
        @(negedge clk);
        model_check();
        src_valid = v;
        src_data  = d;
        ena       = e;
        mode      = md;
        if (m_age < 0) begin
            if (v && e) begin
                m_age  = 0;
                m_data = d;
                m_mode = md;
                // A 4-phase request issued while ack is still high is acknowledged at once.
                m_h1   = (!md && m_req) ? 1 : HALF;
                m_req  = md ? ~m_req : 1'b1;
            end
        end else begin
            m_age++;
            if (!m_mode && m_age == m_h1) m_req = 1'b0;
            if (m_age == (m_mode ? HALF : m_h1 + HALF)) begin
                m_age = -1;
                m_cnt++;
            end
        end
    endtask

    task automatic run_xfer(input logic md, input logic [DW-1:0] d);
        bit acc;
        int g;
        acc = 1'b0;
        g = 0;
        while (!acc && g < 40) begin
            acc = (m_age < 0);
            step(1'b1, d, 1'b1, md);
            g++;
        end
        g = 0;
        while (m_age >= 0 && g < 40) begin
            step(1'b0, d, 1'b1, md);
            g++;
        end
        if (m_age >= 0) guard_fail("xfer_guard");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        tbl[0] = '{ena: 1'b0, valid: 1'b0, exp_ready: 1'b0};
        tbl[1] = '{ena: 1'b0, valid: 1'b1, exp_ready: 1'b0};
        tbl[2] = '{ena: 1'b1, valid: 1'b0, exp_ready: 1'b1};
        tbl[3] = '{ena: 1'b1, valid: 1'b1, exp_ready: 1'b1};
        exp_wrap = '{1, 2, 3, 0, 1};

        // Reset values with ena high: src_ready must still be low.
        @(negedge clk);
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", src_ready, 0);
        rst_n = 1'b1;

        // src_ready depends on ena only, never on src_valid.
        for (int i = 0; i < 4; i++) begin
            ena = tbl[i].ena;
            src_valid = tbl[i].valid;
            #1;
            chk("vec_ready", src_ready, tbl[i].exp_ready);
            chk("vec_busy", busy, 0);
        end
        src_valid = 1'b0;
        ena = 1'b1;

        // 4-phase back to back.
        prev_req = req_out;
        n_rise = 0;
        c0 = m_cnt;
        run_xfer(1'b0, 8'hA5);
        run_xfer(1'b0, 8'h3C);
        chk("4ph_cnt", xfer_cnt, (c0 + 2) % (1 << CW));
        chk("4ph_rises", n_rise, 2);

        // 2-phase, four words.
        n_tog = 0;
        c0 = m_cnt;
        for (int i = 0; i < 4; i++) run_xfer(1'b1, DW'(8'h10 + i));
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("2ph_toggles", n_tog, 4);
        chk("2ph_req_end", req_out, 0);
        chk("2ph_cnt", xfer_cnt, (c0 + 4) % (1 << CW));

        // 4-phase timeout with ack stuck low.
        tie0 = 1'b1;
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        c0 = m_cnt % (1 << CW);
        src_valid = 1'b1;
        src_data = 8'h5A;
        mode = 1'b0;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        for (int j = 1; j <= TMO; j++) begin
            @(posedge clk);
            #1;
            if (j == 3) err_clr = 1'b1;
            if (j == 4) err_clr = 1'b0;
            if (j == TMO - 1) begin
                chk("tmo_early", timeout_err, 0);
                chk("tmo_busy", busy, 1);
            end
        end
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_req", req_out, 1);
        chk("tmo_ready", src_ready, 0);
        chk("tmo_data", data_out, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_busy_err", busy, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_terr", timeout_err, 0);
        chk("clr_req", req_out, 0);
        k = 0;
        while (busy && k < SS + 1) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("clr_idle", busy, 0);
        chk("clr_cnt", xfer_cnt, c0);

        // 2-phase timeout: recovery resyncs req to ack and returns to IDLE directly.
        src_valid = 1'b1;
        src_data = 8'hC3;
        mode = 1'b1;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        chk("2tmo_req", req_out, 1);
        repeat (TMO) @(posedge clk);
        #1;
        chk("2tmo_flag", timeout_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("2clr_busy", busy, 0);
        chk("2clr_req", req_out, 0);
        chk("2clr_terr", timeout_err, 0);
        chk("2clr_cnt", xfer_cnt, c0);
        tie0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        m_age = -1;
        m_req = 1'b0;
        m_data = 8'hC3;
        prev_req = req_out;

        // ena drops one cycle after accept while src_valid stays high.
        c0 = m_cnt;
        step(1'b1, 8'h99, 1'b1, 1'b0);
        repeat (20) step(1'b1, 8'h66, 1'b0, 1'b0);
        chk("ena_cnt", m_cnt, c0 + 1);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        repeat (14) step(1'b0, 8'h66, 1'b1, 1'b0);

        // Asynchronous reset in the middle of ASSERT.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h77, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", req_out, 0);
        chk("arst_data", data_out, 0);
        chk("arst_cnt", xfer_cnt, 0);
        chk("arst_ready", src_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        src_valid = 1'b0;
        #1;
        chk("arst_ready_after", src_ready, 1);
        m_age = -1;
        m_req = 1'b0;
        m_data = '0;
        m_cnt = 0;
        prev_req = 1'b0;

        // Counter wrap with a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            run_xfer(1'b1, DW'(8'hE0 + i));
            chk("wrap_cnt", xfer_cnt, exp_wrap[i]);
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 9) < 8),
                 1'($urandom));
        end
        @(negedge clk);
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
